// File: rtl/dc_sweep_pkg.sv
// dc_sweep_pkg: shared state encoding, default widths and saturating code arithmetic
package dc_sweep_pkg;
   localparam int CODE_W_DEF = 12;
   localparam int IDX_W_DEF  = 10;
   localparam int SET_W_DEF  = 16;
   localparam int MEAS_W_DEF = 16;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_ADV, S_DONE} state_t;
   typedef struct packed {
      logic        clamp;
      logic [31:0] code;
   } sat_t;
   // code is zero-extended, step sign-extended; w is the DAC width (at most 30)
   function automatic sat_t sat_add(input logic [31:0] code, input logic [31:0] step, input int unsigned w);
      logic signed [33:0] s;
      logic signed [33:0] mx;
      sat_t r;
      s = $signed({2'b00, code}) + $signed({{2{step[31]}}, step});
      mx = $signed((34'd1 << w) - 34'd1);
      r.clamp = s[33] | (s > mx);
      r.code = s[33] ? '0 : (s > mx) ? mx[31:0] : s[31:0];
      return r;
   endfunction
endpackage

// File: rtl/dc_sweep_seq_axis.sv
// sweep_axis: one sweep axis holding its DAC code and point index with a saturating step
module sweep_axis
   import dc_sweep_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_rev,
   input  logic [CODE_W-1:0] i_start,
   input  logic [CODE_W:0]   i_inc,
   input  logic [IDX_W-1:0]  i_npts,
   output logic [CODE_W-1:0] o_code,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_last,
   output logic              o_clamp
);
   logic [CODE_W-1:0] r_code;
   logic [IDX_W-1:0]  r_idx;
   logic [31:0]       w_inc;
   sat_t              w_res;
   assign w_inc   = {{(31-CODE_W){i_inc[CODE_W]}}, i_inc};
   assign w_res   = sat_add({{(32-CODE_W){1'b0}}, r_code}, i_rev ? -w_inc : w_inc, CODE_W);
   assign o_clamp = w_res.clamp | (|w_res.code[31:CODE_W]);
   assign o_last  = i_rev ? (r_idx == '0) : (r_idx == i_npts);
   assign o_code  = r_code;
   assign o_idx   = r_idx;
   // code/index register: load restarts the axis, step moves one point in the current direction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code <= '0;
         r_idx  <= '0;
      end else if (i_load) begin
         r_code <= i_start;
         r_idx  <= '0;
      end else if (i_step) begin
         r_code <= w_res.code[CODE_W-1:0];
         r_idx  <= i_rev ? r_idx - IDX_W'(1) : r_idx + IDX_W'(1);
      end
   end
endmodule

// File: rtl/dc_sweep_seq.sv
// dc_sweep_seq: nested outer/inner DC bias sweep sequencer; define SWEEP_SNAKE_EN for a serpentine inner axis
module dc_sweep_seq
   import dc_sweep_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int SET_W  = SET_W_DEF,
   parameter int MEAS_W = MEAS_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CODE_W-1:0] out_start,
   input  logic [CODE_W:0]   out_step,
   input  logic [IDX_W-1:0]  out_npts,
   input  logic [CODE_W-1:0] in_start,
   input  logic [CODE_W:0]   in_step,
   input  logic [IDX_W-1:0]  in_npts,
   input  logic [SET_W-1:0]  settle_cyc,
   output logic [CODE_W-1:0] dac_out,
   output logic [CODE_W-1:0] dac_in,
   output logic              dac_upd,
   output logic              meas_req,
   input  logic              meas_ack,
   input  logic [MEAS_W-1:0] meas_data,
   output logic              smp_valid,
   output logic [MEAS_W-1:0] smp_data,
   output logic [IDX_W-1:0]  smp_oidx,
   output logic [IDX_W-1:0]  smp_iidx,
   output logic              busy,
   output logic              done,
   output logic              clamped
);
   state_t            r_state, w_nxt;
   logic [CODE_W-1:0] r_out_start, r_in_start;
   logic [CODE_W:0]   r_out_step, r_in_step;
   logic [IDX_W-1:0]  r_out_npts, r_in_npts, w_oidx, w_iidx;
   logic [SET_W-1:0]  r_settle, r_cnt;
   logic              w_accept, w_ld, w_istep, w_ostep, w_iload, w_irev, w_cap;
   logic              w_ilast, w_olast, w_iclamp, w_oclamp;
   logic              r_upd, r_sv, r_clamped;
   logic [MEAS_W-1:0] r_sdata;
   logic [IDX_W-1:0]  r_soidx, r_siidx;
   assign w_accept = (r_state == S_IDLE) & start & ~abort;
   assign w_ld     = (r_state == S_LOAD) & ~abort;
   assign w_istep  = (r_state == S_ADV) & ~abort & ~w_ilast;
   assign w_ostep  = (r_state == S_ADV) & ~abort & w_ilast & ~w_olast;
   assign w_cap    = (r_state == S_MEAS) & ~abort & meas_ack;
`ifdef SWEEP_SNAKE_EN
   assign w_iload  = w_ld;
   assign w_irev   = w_oidx[0];
`else
   assign w_iload  = w_ld | w_ostep;
   assign w_irev   = 1'b0;
`endif
   sweep_axis #(.CODE_W(CODE_W), .IDX_W(IDX_W)) u_out (
      .clk(clk), .rst_n(rst_n), .i_load(w_ld), .i_step(w_ostep), .i_rev(1'b0),
      .i_start(r_out_start), .i_inc(r_out_step), .i_npts(r_out_npts),
      .o_code(dac_out), .o_idx(w_oidx), .o_last(w_olast), .o_clamp(w_oclamp)
   );
   sweep_axis #(.CODE_W(CODE_W), .IDX_W(IDX_W)) u_in (
      .clk(clk), .rst_n(rst_n), .i_load(w_iload), .i_step(w_istep), .i_rev(w_irev),
      .i_start(r_in_start), .i_inc(r_in_step), .i_npts(r_in_npts),
      .o_code(dac_in), .o_idx(w_iidx), .o_last(w_ilast), .o_clamp(w_iclamp)
   );
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end
   // next state; abort overrides every transition
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:   w_nxt = start ? S_LOAD : S_IDLE;
         S_LOAD:   w_nxt = S_SETTLE;
         S_SETTLE: w_nxt = (r_cnt <= SET_W'(1)) ? S_MEAS : S_SETTLE;
         S_MEAS:   w_nxt = meas_ack ? S_ADV : S_MEAS;
         S_ADV:    w_nxt = (w_ilast & w_olast) ? S_DONE : S_SETTLE;
         default:  w_nxt = S_IDLE;
      endcase
      if (abort) w_nxt = S_IDLE;
   end
   // config capture at start, settle countdown, update strobe and sticky clamp flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_start <= '0;
         r_out_step  <= '0;
         r_out_npts  <= '0;
         r_in_start  <= '0;
         r_in_step   <= '0;
         r_in_npts   <= '0;
         r_settle    <= '0;
         r_cnt       <= '0;
         r_upd       <= 1'b0;
         r_clamped   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_out_start <= out_start;
            r_out_step  <= out_step;
            r_out_npts  <= out_npts;
            r_in_start  <= in_start;
            r_in_step   <= in_step;
            r_in_npts   <= in_npts;
            r_settle    <= settle_cyc;
         end
         if (w_ld | w_istep | w_ostep) r_cnt <= r_settle;
         else if (r_state == S_SETTLE) r_cnt <= r_cnt - SET_W'(r_cnt != '0);
         r_upd     <= w_ld | w_istep | w_ostep;
         r_clamped <= w_accept ? 1'b0 : r_clamped | (w_istep & w_iclamp) | (w_ostep & w_oclamp);
      end
   end
   // sample capture: result and point indices are registered on the accepted ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sv    <= 1'b0;
         r_sdata <= '0;
         r_soidx <= '0;
         r_siidx <= '0;
      end else begin
         r_sv <= w_cap;
         if (w_cap) begin
            r_sdata <= meas_data;
            r_soidx <= w_oidx;
            r_siidx <= w_iidx;
         end
      end
   end
   assign dac_upd   = r_upd;
   assign meas_req  = r_state == S_MEAS;
   assign smp_valid = r_sv;
   assign smp_data  = r_sdata;
   assign smp_oidx  = r_soidx;
   assign smp_iidx  = r_siidx;
   assign busy      = r_state != S_IDLE;
   assign done      = r_state == S_DONE;
   assign clamped   = r_clamped;
endmodule

// File: tb/tb_dc_sweep_seq.sv
// tb_dc_sweep_seq: directed bench for dc_sweep_seq (serpentine checks when SWEEP_SNAKE_EN is defined)
module tb_dc_sweep_seq;
   localparam int CW = 12, CW1 = 13, IW = 10, SW = 16, MW = 16;
`ifdef SWEEP_SNAKE_EN
   localparam bit SNAKE = 1'b1;
`else
   localparam bit SNAKE = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, meas_ack = 1'b0;
   logic [CW-1:0] out_start = '0, in_start = '0;
   logic [CW:0]   out_step = '0, in_step = '0;
   logic [IW-1:0] out_npts = '0, in_npts = '0;
   logic [SW-1:0] settle_cyc = '0;
   logic [MW-1:0] meas_data = '0;
   logic [CW-1:0] dac_out, dac_in;
   logic          dac_upd, meas_req, smp_valid, busy, done, clamped;
   logic [MW-1:0] smp_data;
   logic [IW-1:0] smp_oidx, smp_iidx;
   int n_cmp = 0, n_bad = 0;
   int q_o[$], q_i[$], q_do[$], q_di[$], q_d[$], q_t[$];
   int n_upd, n_done, first_req, n_cyc;

   dc_sweep_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .out_start(out_start), .out_step(out_step), .out_npts(out_npts),
      .in_start(in_start), .in_step(in_step), .in_npts(in_npts), .settle_cyc(settle_cyc),
      .dac_out(dac_out), .dac_in(dac_in), .dac_upd(dac_upd), .meas_req(meas_req),
      .meas_ack(meas_ack), .meas_data(meas_data), .smp_valid(smp_valid), .smp_data(smp_data),
      .smp_oidx(smp_oidx), .smp_iidx(smp_iidx), .busy(busy), .done(done), .clamped(clamped)
   );

   always #5 clk = ~clk;

   function automatic int exp_i(input int o, input int k, input int n);
      return (SNAKE && (o % 2 == 1)) ? n - k : k;
   endfunction

   task automatic cfg(input int os, input int ost, input int on, input int is, input int ist, input int inn, input int st);
      out_start = CW'(os);
      out_step = CW1'(ost);
      out_npts = IW'(on);
      in_start = CW'(is);
      in_step = CW1'(ist);
      in_npts = IW'(inn);
      settle_cyc = SW'(st);
   endtask

   // starts a sweep and acts as the measurement instrument until the sequencer is idle again
   task automatic run(input int ack_dly, input bit tie, input int budget);
      int req_run = 0;
      q_o.delete(); q_i.delete(); q_do.delete(); q_di.delete(); q_d.delete(); q_t.delete();
      n_upd = 0; n_done = 0; first_req = -1; n_cyc = 0;
      meas_ack = tie;
      meas_data = MW'(16'hA000);
      @(negedge clk);
      start = 1'b1;
      do begin
         @(negedge clk);
         n_cyc++;
         if (n_cyc == 1) start = 1'b0;
         if (dac_upd) n_upd++;
         if (done) n_done++;
         if (smp_valid) begin
            q_o.push_back(int'(smp_oidx)); q_i.push_back(int'(smp_iidx));
            q_do.push_back(int'(dac_out)); q_di.push_back(int'(dac_in));
            q_d.push_back(int'(smp_data)); q_t.push_back(n_cyc);
         end
         if (meas_req && first_req < 0) first_req = n_cyc;
         if (!tie) begin
            req_run = meas_req ? req_run + 1 : 0;
            meas_ack = meas_req && (req_run > ack_dly);
         end
         meas_data = MW'(16'hA000 + q_o.size());
      end while (busy && n_cyc < budget);
      meas_ack = 1'b0;
      n_cmp++;
      if (n_cyc >= budget) begin
         n_bad++;
         $display("FAIL run_timeout: still busy after %0d cycles (limit %0d)", n_cyc, budget);
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({dac_out, dac_in, dac_upd, meas_req, smp_valid, smp_data, smp_oidx, smp_iidx, busy, done, clamped} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got out=%0d in=%0d busy=%b req=%b, required all zero", dac_out, dac_in, busy, meas_req);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_basic();
      cfg(100, 50, 1, 0, 10, 2, 3);
      run(1, 1'b0, 300);
      n_cmp++;
      if (q_o.size() != 6) begin n_bad++; $display("FAIL basic_count: got %0d samples, required 6", q_o.size()); end
      for (int k = 0; k < 6 && k < q_o.size(); k++) begin
         n_cmp++;
         if (q_o[k] != k / 3 || q_i[k] != exp_i(k / 3, k % 3, 2)) begin
            n_bad++;
            $display("FAIL basic_idx[%0d]: got (%0d,%0d), required (%0d,%0d)", k, q_o[k], q_i[k], k / 3, exp_i(k / 3, k % 3, 2));
         end
         n_cmp++;
         if (q_do[k] != 100 + 50 * (k / 3) || q_di[k] != 10 * exp_i(k / 3, k % 3, 2)) begin
            n_bad++;
            $display("FAIL basic_code[%0d]: got (%0d,%0d), required (%0d,%0d)", k, q_do[k], q_di[k], 100 + 50 * (k / 3), 10 * exp_i(k / 3, k % 3, 2));
         end
         n_cmp++;
         if (q_d[k] != 16'hA000 + k) begin
            n_bad++;
            $display("FAIL basic_data[%0d]: got %h, required %h", k, q_d[k], 16'hA000 + k);
         end
      end
      n_cmp++;
      if (n_done != 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses, required 1", n_done); end
      n_cmp++;
      if (clamped !== 1'b0) begin n_bad++; $display("FAIL basic_clamped: got %b, required 0", clamped); end
      n_cmp++;
      if (first_req != 5) begin n_bad++; $display("FAIL basic_latency: first req at %0d, required 5", first_req); end
      n_cmp++;
      if (n_upd != 6) begin n_bad++; $display("FAIL basic_upd: got %0d pulses, required 6", n_upd); end
      n_cmp++;
      if (dac_out !== CW'(150) || dac_in !== CW'(10 * exp_i(1, 2, 2))) begin
         n_bad++;
         $display("FAIL basic_hold: got (%0d,%0d), required (150,%0d)", dac_out, dac_in, 10 * exp_i(1, 2, 2));
      end
   endtask

   task automatic test_sat();
      cfg(0, 0, 0, 4090, 4, 2, 1);
      run(0, 1'b0, 200);
      n_cmp++;
      if (q_di.size() != 3 || q_di[0] != 4090 || q_di[1] != 4094 || q_di[2] != 4095) begin
         n_bad++;
         $display("FAIL sat_hi_codes: got %0d samples, required 4090,4094,4095", q_di.size());
      end
      n_cmp++;
      if (clamped !== 1'b1) begin n_bad++; $display("FAIL sat_hi_clamped: got %b, required 1", clamped); end
      cfg(0, 0, 0, 3, -2, 2, 1);
      run(0, 1'b0, 200);
      n_cmp++;
      if (q_di.size() != 3 || q_di[0] != 3 || q_di[1] != 1 || q_di[2] != 0) begin
         n_bad++;
         $display("FAIL sat_lo_codes: got %0d samples, required 3,1,0", q_di.size());
      end
      n_cmp++;
      if (clamped !== 1'b1) begin n_bad++; $display("FAIL sat_lo_clamped: got %b, required 1", clamped); end
   endtask

   task automatic test_zero_settle();
      cfg(7, 1, 1, 5, 2, 2, 0);
      run(0, 1'b1, 200);
      n_cmp++;
      if (first_req != 3) begin n_bad++; $display("FAIL zero_latency: first req at %0d, required 3", first_req); end
      n_cmp++;
      if (q_t.size() != 6) begin n_bad++; $display("FAIL zero_count: got %0d samples, required 6", q_t.size()); end
      n_cmp++;
      if (q_t.size() > 0 && q_t[0] != 4) begin n_bad++; $display("FAIL zero_first_smp: at cycle %0d, required 4", q_t[0]); end
      for (int k = 1; k < q_t.size(); k++) begin
         n_cmp++;
         if (q_t[k] - q_t[k-1] != 3) begin
            n_bad++;
            $display("FAIL zero_spacing[%0d]: got %0d cycles, required 3", k, q_t[k] - q_t[k-1]);
         end
      end
      n_cmp++;
      if (q_di.size() == 6 && (q_do[4] != 8 || q_di[4] != 5 + 2 * exp_i(1, 1, 2))) begin
         n_bad++;
         $display("FAIL zero_code: got (%0d,%0d), required (8,%0d)", q_do[4], q_di[4], 5 + 2 * exp_i(1, 1, 2));
      end
      n_cmp++;
      if (clamped !== 1'b0) begin n_bad++; $display("FAIL zero_clamp_clear: got %b, required 0", clamped); end
   endtask

   task automatic test_abort();
      int c = 0, req_run = 0, late = 0;
      bit hit = 1'b0;
      cfg(100, 50, 1, 0, 10, 2, 3);
      q_o.delete();
      @(negedge clk);
      start = 1'b1;
      while (!hit && c < 200) begin
         @(negedge clk);
         c++;
         if (c == 1) start = 1'b0;
         if (smp_valid) q_o.push_back(int'(smp_oidx));
         if (meas_req && q_o.size() == 2) begin
            abort = 1'b1;
            meas_ack = 1'b0;
            hit = 1'b1;
         end else begin
            req_run = meas_req ? req_run + 1 : 0;
            meas_ack = meas_req && (req_run > 1);
         end
      end
      n_cmp++;
      if (!hit) begin n_bad++; $display("FAIL abort_reach: point 2 not reached in %0d cycles", c); end
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || meas_req !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_idle: busy=%b req=%b done=%b, required 0 0 0", busy, meas_req, done);
      end
      n_cmp++;
      if (dac_out !== CW'(100) || dac_in !== CW'(20)) begin
         n_bad++;
         $display("FAIL abort_hold: got (%0d,%0d), required (100,20)", dac_out, dac_in);
      end
      meas_ack = 1'b1;
      @(negedge clk);
      meas_ack = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (smp_valid || done || busy) late++;
      end
      n_cmp++;
      if (late != 0) begin n_bad++; $display("FAIL abort_late_ack: %0d active cycles, required 0", late); end
      run(1, 1'b0, 300);
      n_cmp++;
      if (q_o.size() != 6 || n_done != 1) begin
         n_bad++;
         $display("FAIL abort_restart: got %0d samples %0d done, required 6 1", q_o.size(), n_done);
      end
   endtask

`ifdef SWEEP_SNAKE_EN
   task automatic test_snake();
      int e_i[6] = '{0, 1, 2, 2, 1, 0};
      int e_di[6] = '{0, 10, 20, 20, 10, 0};
      int e_do[6] = '{0, 0, 0, 5, 5, 5};
      cfg(0, 5, 1, 0, 10, 2, 0);
      run(0, 1'b0, 200);
      n_cmp++;
      if (q_i.size() != 6) begin n_bad++; $display("FAIL snake_count: got %0d samples, required 6", q_i.size()); end
      for (int k = 0; k < 6 && k < q_i.size(); k++) begin
         n_cmp++;
         if (q_i[k] != e_i[k] || q_di[k] != e_di[k] || q_do[k] != e_do[k]) begin
            n_bad++;
            $display("FAIL snake[%0d]: got iidx=%0d in=%0d out=%0d, required %0d %0d %0d", k, q_i[k], q_di[k], q_do[k], e_i[k], e_di[k], e_do[k]);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      cfg(100, 50, 1, 0, 10, 2, 20);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || dac_out !== CW'(100)) begin
         n_bad++;
         $display("FAIL rstmid_pre: busy=%b out=%0d, required 1 100", busy, dac_out);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({dac_out, dac_in, dac_upd, meas_req, smp_valid, smp_data, smp_oidx, smp_iidx, busy, done, clamped} !== '0) begin
         n_bad++;
         $display("FAIL rstmid_async: got out=%0d busy=%b smp=%h, required all zero", dac_out, busy, smp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || meas_req !== 1'b0 || dac_out !== '0) begin
         n_bad++;
         $display("FAIL rstmid_idle: busy=%b req=%b out=%0d, required 0 0 0", busy, meas_req, dac_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sat();
      test_zero_settle();
      test_abort();
`ifdef SWEEP_SNAKE_EN
      test_snake();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dc_sweep_seq.md
Name: dc_sweep_seq

Overview:
- Digital sequencer for two-axis DC I-V characterisation of a three-terminal FET (gate/drain sweep), e.g. for Curtice-type model extraction.
- Drives an outer-axis (Vgs) DAC code and an inner-axis (Vds) DAC code through a nested sweep.
- For each bias point: waits a programmable settle time, requests one measurement, streams the result out tagged with the point indices.
- Generalises the single-point bias source to N×M points with programmable start, step, count and settle time.

Parameters:
- CODE_W, 12, DAC code width (unsigned)
- IDX_W, 10, width of point counters; max points per axis = 2^IDX_W
- SET_W, 16, width of the settle-cycle counter
- MEAS_W, 16, measurement data width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only in IDLE; samples all config inputs
- abort  in  1  pulse; returns to IDLE from any state
- out_start  in  CODE_W  outer first code
- out_step  in  CODE_W+1  outer signed step
- out_npts  in  IDX_W  outer point count minus 1
- in_start  in  CODE_W  inner first code
- in_step  in  CODE_W+1  inner signed step
- in_npts  in  IDX_W  inner point count minus 1
- settle_cyc  in  SET_W  settle cycles per point
- dac_out  out  CODE_W  outer DAC code
- dac_in  out  CODE_W  inner DAC code
- dac_upd  out  1  one-cycle pulse when either code changes
- meas_req  out  1  level; held until meas_ack
- meas_ack  in  1  measurement valid
- meas_data  in  MEAS_W  measurement value
- smp_valid  out  1  one-cycle result strobe
- smp_data  out  MEAS_W  registered meas_data
- smp_oidx  out  IDX_W  outer index of the sample
- smp_iidx  out  IDX_W  inner index of the sample
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at normal completion
- clamped  out  1  sticky per sweep; set when any code saturated

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; config registers 0.
- FSM states: IDLE → LOAD → SETTLE → MEAS → ADV → (SETTLE | DONE) → IDLE.
- IDLE: start latches config, clears clamped, and goes to LOAD.
- LOAD (1 cycle):
  - dac_out = out_start, dac_in = in_start, both indices = 0.
  - dac_upd pulses; settle counter loaded with settle_cyc.
- SETTLE:
  - Counter decrements each cycle; leaves when counter == 0.
  - settle_cyc = 0 means SETTLE lasts exactly 1 cycle.
- MEAS:
  - meas_req is high.
  - On meas_ack: meas_req drops, smp_* register with smp_valid = 1 the next cycle, then go to ADV.
  - meas_ack outside MEAS is ignored.
  - meas_ack in the first MEAS cycle is legal.
- ADV (1 cycle):
  - If iidx < in_npts: iidx++, dac_in += in_step.
  - Else if oidx < out_npts: iidx = 0, dac_in = in_start, oidx++, dac_out += out_step.
  - Else: go to DONE.
  - Any code change pulses dac_upd and reloads the settle counter.
- DONE: done pulses for 1 cycle, then IDLE. DAC codes hold their last values.
- Arithmetic:
  - code + step is computed at CODE_W+2 bits signed.
  - Result < 0 clamps to 0; result > 2^CODE_W−1 clamps to max; either case sets clamped.
  - The sweep continues after a clamp.
- Latency: start → first meas_req = 2 + max(settle_cyc,1) cycles.
- Point count: exactly (out_npts+1)·(in_npts+1) smp_valid strobes per sweep.
- Abort: takes priority over every other transition.
  - Next cycle: IDLE, meas_req = 0, no done pulse.
  - DAC codes hold; clamped holds.
- start while busy is ignored.
- Asynchronous reset mid-sweep: all state returns to reset values immediately.

Optional Feature:
- SWEEP_SNAKE_EN defined:
  - Inner axis is serpentine: on odd oidx the inner sweep runs from the last inner code back toward in_start, using the negated step.
  - At each outer advance, dac_in is unchanged, so only dac_out moves.
  - smp_iidx always reports physical position: counts down on odd rows.
- Not defined: the inner axis restarts from in_start on every outer row.

Decomposition:
- Package dc_sweep_pkg:
  - state enum (IDLE, LOAD, SETTLE, MEAS, ADV, DONE)
  - default width constants
  - saturating add function sat_add(code, step) returning code and clamp flag
- Sub-module sweep_axis (instantiated twice):
  - holds code and index
  - load, step and reverse inputs
  - last-point and clamp outputs

Test Plan:
- Basic sweep:
  - Stimulus: out 100/+50/npts 1, in 0/+10/npts 2, settle 3, ack 1 cycle after req.
  - Response: 6 samples; (oidx,iidx,dac_out,dac_in) = (0,0,100,0) … (1,2,150,20); then done; clamped = 0.
- Saturation:
  - Stimulus: in_start 4090, step +4, npts 2, CODE_W = 12.
  - Response: dac_in 4090, 4094, 4095; clamped = 1.
  - Repeat with in_start 3, step −2: dac_in 3, 1, 0.
- Zero settle / instant ack:
  - Stimulus: settle 0, meas_ack tied high.
  - Response: first meas_req at cycle 3 after start; one sample per 3 cycles (SETTLE, MEAS, ADV).
- Abort mid-sweep:
  - Stimulus: abort during MEAS at point 2.
  - Response: next cycle busy = 0, meas_req = 0, no done; late ack ignored; a new start runs a full sweep.
- Snake (SWEEP_SNAKE_EN):
  - Stimulus: in 0/+10/npts 2, out npts 1.
  - Response: dac_in sequence 0,10,20,20,10,0; iidx 0,1,2,2,1,0; only dac_out changes at the row switch.
- Reset mid-settle:
  - Stimulus: rst_n low asynchronously.
  - Response: all outputs 0 within the same cycle; the FSM stays IDLE after rst_n is released.
